// File: rtl/mul_unit_pkg.sv
// Shared types and constants for the iterative multiplier.
package mul_unit_pkg;

    localparam int MUL_STATE_LEN = 2;
    localparam int MUL_STEP_BITS = 4;
    localparam int REGISTER_LEN  = 4;

    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;

    typedef enum logic [MUL_STATE_LEN-1:0] {
        MUL_STATE_IDLE = 2'd0,
        MUL_STATE_RUN  = 2'd1,
        MUL_STATE_DONE = 2'd2
    } mul_state_e;

endpackage

// File: rtl/mul_unit_if.sv
// EXE-stage multiplier bus: operands and control in, result and pipeline control out.
interface mul_unit_if
    import mul_unit_pkg::*;
#(
    parameter int WIDTH = 32
) ();

    logic                    start;
    logic                    flush;
    logic [WIDTH-1:0]        operand_a;
    logic [WIDTH-1:0]        operand_b;
    logic [REGISTER_LEN-1:0] dest_in;
    logic                    s_in;

    logic [WIDTH-1:0]        result;
    logic [REGISTER_LEN-1:0] dest_out;
    logic                    wb_enable_out;
    logic                    status_write_out;
    logic                    n_out;
    logic                    z_out;
    logic                    busy;
    logic                    stall;
    logic                    done;

    modport master (
        output start, flush, operand_a, operand_b, dest_in, s_in,
        input  result, dest_out, wb_enable_out, status_write_out,
        input  n_out, z_out, busy, stall, done
    );

    modport slave (
        input  start, flush, operand_a, operand_b, dest_in, s_in,
        output result, dest_out, wb_enable_out, status_write_out,
        output n_out, z_out, busy, stall, done
    );

endinterface

// File: rtl/mul_unit_step.sv
// One radix-2^STEP_BITS iteration: acc + mcand * digit, truncated to WIDTH bits.
module mul_unit_step #(
    parameter int WIDTH     = 32,
    parameter int STEP_BITS = 4
) (
    input  logic [WIDTH-1:0]     acc_in,
    input  logic [WIDTH-1:0]     mcand,
    input  logic [STEP_BITS-1:0] digit,
    output logic [WIDTH-1:0]     acc_out
);

    // Shift-and-add over the digit bits; carries above WIDTH fall off.
    always_comb begin
        acc_out = acc_in;
        for (int i = 0; i < STEP_BITS; i++) begin
            if (digit[i]) begin
                acc_out = acc_out + (mcand << i);
            end
        end
    end

endmodule

// File: rtl/mul_unit.sv
// Iterative multiplier for the EXE stage. Holds the pipeline via stall while
// running, then presents the low WIDTH bits of the product for one DONE cycle.
module mul_unit
    import mul_unit_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int STEP_BITS = MUL_STEP_BITS,
    parameter bit EARLY_OUT = 1'b1
) (
    input  logic     clk,
    input  logic     rst,
    mul_unit_if.slave bus
);

    localparam int ITERS = WIDTH / STEP_BITS;
    localparam int CNT_W = $clog2(ITERS + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ITERS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

    mul_state_e              state_q, state_d;
    logic [WIDTH-1:0]        acc_q, acc_d;
    logic [WIDTH-1:0]        mcand_q, mcand_d;
    logic [WIDTH-1:0]        mplier_q, mplier_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [REGISTER_LEN-1:0] dest_q, dest_d;
    logic                    s_q, s_d;
    logic [WIDTH-1:0]        acc_step;
    logic                    in_done;
    logic                    fire;

    mul_unit_step #(
        .WIDTH    (WIDTH),
        .STEP_BITS(STEP_BITS)
    ) u_step (
        .acc_in (acc_q),
        .mcand  (mcand_q),
        .digit  (mplier_q[STEP_BITS-1:0]),
        .acc_out(acc_step)
    );

    // Next-state and datapath update: load in IDLE, iterate in RUN, retire in DONE.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        dest_d   = dest_q;
        s_d      = s_q;
        case (state_q)
            MUL_STATE_IDLE: begin
                if (bus.start && !bus.flush) begin
                    acc_d    = '0;
                    mcand_d  = bus.operand_a;
                    mplier_d = bus.operand_b;
                    cnt_d    = CNT_LOAD;
                    dest_d   = bus.dest_in;
                    s_d      = bus.s_in;
                    state_d  = MUL_STATE_RUN;
                end
            end
            MUL_STATE_RUN: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << STEP_BITS;
                mplier_d = mplier_q >> STEP_BITS;
                cnt_d    = cnt_q - CNT_LAST;
                // Early-out looks at what is left after this digit is consumed.
                if (cnt_q == CNT_LAST || (EARLY_OUT && mplier_d == '0)) begin
                    state_d = MUL_STATE_DONE;
                end
                if (bus.flush) begin
                    state_d = MUL_STATE_IDLE;
                end
            end
            MUL_STATE_DONE: begin
                // start is still the same instruction here, so never restart.
                state_d = MUL_STATE_IDLE;
            end
            default: begin
                state_d = MUL_STATE_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= MUL_STATE_IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            dest_q   <= '0;
            s_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            dest_q   <= dest_d;
            s_q      <= s_d;
        end
    end

    // Outputs decode the registered state; only flush may veto a DONE strobe.
    always_comb begin
        in_done              = (state_q == MUL_STATE_DONE);
        fire                 = in_done && !bus.flush;
        bus.result           = in_done ? acc_q : '0;
        bus.n_out            = in_done && acc_q[WIDTH-1];
        bus.z_out            = in_done && (acc_q == '0);
        bus.dest_out         = dest_q;
        bus.done             = fire ? ENABLE : DISABLE;
        bus.wb_enable_out    = fire ? ENABLE : DISABLE;
        bus.status_write_out = fire && s_q;
        bus.busy             = (state_q != MUL_STATE_IDLE);
        bus.stall            = ((state_q == MUL_STATE_IDLE) && bus.start && !bus.flush)
                               || (state_q == MUL_STATE_RUN);
    end

endmodule

// File: doc/mul_unit.md
Name: mul_unit

Overview:
- Iterative multi-cycle multiplier in the EXE stage, directly downstream of the decode control logic.
- Consumes the decoded multiply indication (is_mul) and register operands from the ID/EX register.
- Computes the low WIDTH bits of operand_a*operand_b over several cycles, freezing the pipeline through a stall output.
- Presents result, destination, writeback enable and N/Z flags for one cycle when complete.

Parameters:
WIDTH, 32, operand and result width in bits
STEP_BITS, 4, multiplier bits consumed per iteration; WIDTH must be a multiple of STEP_BITS
EARLY_OUT, 1, when 1, finish as soon as the remaining multiplier bits are zero

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
start  input  1  is_mul of the instruction currently in EXE (valid-qualified upstream)
flush  input  1  branch-taken flush; aborts any operation in flight
operand_a  input  WIDTH  Rm value (multiplicand)
operand_b  input  WIDTH  Rs value (multiplier)
dest_in  input  4  destination register number
s_in  input  1  S bit of the instruction
result  output  WIDTH  product, low WIDTH bits
dest_out  output  4  latched destination
wb_enable_out  output  1  writeback strobe, high only in DONE
status_write_out  output  1  latched S bit AND done
n_out  output  1  result[WIDTH-1]
z_out  output  1  result == 0
busy  output  1  state != IDLE
stall  output  1  freeze request to PC, IF/ID and ID/EX registers
done  output  1  high for exactly one cycle when result is valid

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE; accumulator, multiplicand, multiplier, counter, dest, s cleared. All outputs 0.
- States are IDLE, RUN and DONE, with 2-bit encoding in Defines.v.
- IDLE:
  - start=1 and flush=0: latch a, b, dest_in and s_in; clear the accumulator; counter=WIDTH/STEP_BITS; go to RUN.
  - Otherwise stay in IDLE.
- RUN, once per cycle:
  - acc <= acc + (mcand * mplier[STEP_BITS-1:0]), truncated to WIDTH bits.
  - mcand <= mcand << STEP_BITS; mplier <= mplier >> STEP_BITS; counter <= counter-1.
  - Go to DONE when counter==1, or when EARLY_OUT=1 and (mplier >> STEP_BITS)==0.
  - start is ignored while in RUN.
- DONE:
  - result=acc; done=1; wb_enable_out=1; status_write_out=latched s.
  - Next state is unconditionally IDLE. start is ignored because it is still the same instruction.
- stall is combinational: (state==IDLE && start && !flush) || state==RUN. It is 0 in DONE, so the multiply leaves EXE at the end of the DONE cycle together with its result.
- Latency: start seen in cycle T. Without early-out, done is in cycle T+WIDTH/STEP_BITS+1 (T+9 at defaults). With early-out, done is at T+1+ceil(significant_bits(b)/STEP_BITS), minimum T+2 (b=0 takes one RUN cycle).
- Back-to-back multiplies: the next is_mul arrives in the cycle after DONE (state IDLE) and starts normally. There is no dead cycle beyond DONE.
- flush:
  - In RUN or DONE: next state IDLE, and done, wb_enable_out and status_write_out are forced 0 that cycle.
  - flush together with start in IDLE: flush wins, no start.
- rst during RUN/DONE: immediate return to IDLE with outputs 0, no writeback.
- Overflow: high product bits are discarded (MUL semantics). C and V flags are not produced; the status register keeps them.
- All outputs other than stall are registered-state-derived (no combinational path from operands).

Decomposition:
- Defines.v additions: MUL_STATE_IDLE/RUN/DONE, MUL_STATE_LEN, MUL_STEP_BITS default; reuse REGISTER_LEN, ENABLE/DISABLE.
- One natural sub-module: mul_step, a combinational WIDTH x STEP_BITS partial-product adder (acc + mcand*digit). mul_unit holds the FSM, shift registers and counter.

Test Plan:
- a=7, b=6, start one instruction with s_in=1 -> stall high T..T+1, done at T+2 (early-out), result=42, n_out=0, z_out=0, status_write_out=1.
- EARLY_OUT=0, a=0xFFFFFFFF, b=0xFFFFFFFF -> done at exactly T+9, result=0x00000001, stall high for 9 cycles (T..T+8).
- a=0x80000000, b=1, s_in=1 -> result=0x80000000, n_out=1; then a=0x12345678, b=0 -> result=0, z_out=1, done at T+2.
- Start a=0x10000, b=0x10000, assert flush at T+2 -> state IDLE at T+3, done/wb_enable_out never asserted, stall 0 from T+3.
- Two multiplies in consecutive instructions (3*5 then 9*9) -> done pulses with 15 then 81, each exactly one cycle, no duplicate start from a held start.
- rst asserted at T+3 of a run -> at T+4 all outputs 0, busy=0; a fresh start afterwards completes correctly.
